// File: rtl/serv_ibus_prefetch.sv
// Single-entry instruction prefetch buffer between the Wishbone instruction bus and the core fetch port.
// After each delivered word the next sequential word is fetched speculatively so sequential fetches complete in one cycle.
module serv_ibus_prefetch #(
  parameter int ADR_W    = 32,
  parameter int PREFETCH = 1
) (
  input  logic             clk,
  input  logic             i_rst_n,
  input  logic             i_invalidate,
  input  logic             i_cpu_cyc,
  input  logic [ADR_W-1:0] i_cpu_adr,
  output logic [31:0]      o_cpu_rdt,
  output logic             o_cpu_ack,
  output logic             o_pf_hit,
  output logic             o_wb_cyc,
  output logic [ADR_W-1:0] o_wb_adr,
  input  logic [31:0]      i_wb_rdt,
  input  logic             i_wb_ack
);

  typedef enum logic [1:0] {S_IDLE, S_FETCH, S_PF, S_DISCARD} state_t;

  localparam bit               PF_EN = (PREFETCH != 0);
  localparam logic [ADR_W-1:0] WORD  = ADR_W'(4);

  state_t           state_q, state_d;
  logic [31:0]      buf_q, buf_d;
  logic             buf_valid_q, buf_valid_d;
  logic             claimed_q, claimed_d;
  logic             pend_q, pend_d;
  logic [ADR_W-1:0] pend_adr_q, pend_adr_d;
  logic [ADR_W-1:0] pf_adr_q, pf_adr_d;
  logic             wb_cyc_q, wb_cyc_d;
  logic [ADR_W-1:0] wb_adr_q, wb_adr_d;
  logic             cpu_ack_q, cpu_ack_d;
  logic             pf_hit_q, pf_hit_d;
  logic [31:0]      cpu_rdt_q, cpu_rdt_d;

  logic             req;
  logic             pf_match;
  logic             wb_ack;
  logic [ADR_W-1:0] cpu_word;

  assign req      = i_cpu_cyc & ~cpu_ack_q;
  assign cpu_word = {i_cpu_adr[ADR_W-1:2], 2'b00};
  assign pf_match = (i_cpu_adr[ADR_W-1:2] == pf_adr_q[ADR_W-1:2]);
  assign wb_ack   = i_wb_ack & wb_cyc_q;

  always_comb begin
    state_d     = state_q;
    buf_d       = buf_q;
    buf_valid_d = buf_valid_q;
    claimed_d   = claimed_q;
    pend_d      = pend_q;
    pend_adr_d  = pend_adr_q;
    pf_adr_d    = pf_adr_q;
    wb_cyc_d    = wb_cyc_q;
    wb_adr_d    = wb_adr_q;
    cpu_ack_d   = 1'b0;
    pf_hit_d    = 1'b0;
    cpu_rdt_d   = cpu_rdt_q;

    if (i_invalidate) begin
      buf_valid_d = 1'b0;
    end

    case (state_q)
      S_IDLE: begin
        if (req) begin
          if (buf_valid_q && pf_match && !i_invalidate) begin
            cpu_ack_d   = 1'b1;
            pf_hit_d    = 1'b1;
            cpu_rdt_d   = buf_q;
            buf_valid_d = 1'b0;
            if (PF_EN) begin
              state_d  = S_PF;
              pf_adr_d = pf_adr_q + WORD;
              wb_cyc_d = 1'b1;
              wb_adr_d = pf_adr_q + WORD;
            end
          end else begin
            buf_valid_d = 1'b0;
            state_d     = S_FETCH;
            wb_cyc_d    = 1'b1;
            wb_adr_d    = cpu_word;
          end
        end
      end

      S_FETCH: begin
        // Entered with the bus idle only after a discard: launch the stored address.
        if (!wb_cyc_q) begin
          wb_cyc_d = 1'b1;
          wb_adr_d = pend_adr_q;
          pend_d   = 1'b0;
        end else if (wb_ack) begin
          wb_cyc_d  = 1'b0;
          cpu_ack_d = 1'b1;
          cpu_rdt_d = i_wb_rdt;
          if (PF_EN) begin
            state_d   = S_PF;
            pf_adr_d  = wb_adr_q + WORD;
            claimed_d = 1'b0;
          end else begin
            state_d = S_IDLE;
          end
        end
      end

      S_PF: begin
        if (!wb_cyc_q) begin
          if (i_invalidate) begin
            state_d = S_IDLE;
          end else begin
            wb_cyc_d = 1'b1;
            wb_adr_d = pf_adr_q;
          end
        end else if (claimed_q || (req && pf_match && !i_invalidate)) begin
          if (wb_ack) begin
            wb_cyc_d  = 1'b0;
            cpu_ack_d = 1'b1;
            pf_hit_d  = 1'b1;
            cpu_rdt_d = i_wb_rdt;
            claimed_d = 1'b0;
            pf_adr_d  = pf_adr_q + WORD;
          end else begin
            claimed_d = 1'b1;
          end
        end else if (i_invalidate || req) begin
          // Unclaimed speculative word is unwanted: jump or invalidation.
          pend_d     = req;
          pend_adr_d = cpu_word;
          if (wb_ack) begin
            wb_cyc_d = 1'b0;
            state_d  = req ? S_FETCH : S_IDLE;
          end else begin
            state_d = S_DISCARD;
          end
        end else if (wb_ack) begin
          wb_cyc_d    = 1'b0;
          buf_d       = i_wb_rdt;
          buf_valid_d = 1'b1;
          state_d     = S_IDLE;
        end
      end

      S_DISCARD: begin
        if (wb_ack) begin
          wb_cyc_d = 1'b0;
          state_d  = pend_q ? S_FETCH : S_IDLE;
        end else if (req && !pend_q) begin
          pend_d     = 1'b1;
          pend_adr_d = cpu_word;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!i_rst_n) begin
      state_q     <= S_IDLE;
      buf_q       <= '0;
      buf_valid_q <= 1'b0;
      claimed_q   <= 1'b0;
      pend_q      <= 1'b0;
      pend_adr_q  <= '0;
      pf_adr_q    <= '0;
      wb_cyc_q    <= 1'b0;
      wb_adr_q    <= '0;
      cpu_ack_q   <= 1'b0;
      pf_hit_q    <= 1'b0;
      cpu_rdt_q   <= '0;
    end else begin
      state_q     <= state_d;
      buf_q       <= buf_d;
      buf_valid_q <= buf_valid_d;
      claimed_q   <= claimed_d;
      pend_q      <= pend_d;
      pend_adr_q  <= pend_adr_d;
      pf_adr_q    <= pf_adr_d;
      wb_cyc_q    <= wb_cyc_d;
      wb_adr_q    <= wb_adr_d;
      cpu_ack_q   <= cpu_ack_d;
      pf_hit_q    <= pf_hit_d;
      cpu_rdt_q   <= cpu_rdt_d;
    end
  end

  assign o_cpu_rdt = cpu_rdt_q;
  assign o_cpu_ack = cpu_ack_q;
  assign o_pf_hit  = pf_hit_q;
  assign o_wb_cyc  = wb_cyc_q;
  assign o_wb_adr  = wb_adr_q;

endmodule

// File: tb/tb_serv_ibus_prefetch.sv
// Directed bench for serv_ibus_prefetch: one prefetching instance, one pass-through instance,
// each served by a memory that acks on the fourth cycle of o_wb_cyc.
module tb_serv_ibus_prefetch;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n, inval, inval2, stray_ack;
  logic        cyc1, cpu_ack1, pf_hit1, wb_cyc1, wb_ack1, resp_ack1;
  logic [31:0] adr1, cpu_rdt1, wb_adr1, wb_rdt1;
  logic        cyc2, cpu_ack2, pf_hit2, wb_cyc2, wb_ack2;
  logic [31:0] adr2, cpu_rdt2, wb_adr2, wb_rdt2;

  int n_checks = 0;
  int n_err    = 0;

  assign wb_ack1 = resp_ack1 | stray_ack;

  serv_ibus_prefetch #(.ADR_W(32), .PREFETCH(1)) dut1 (
    .clk(clk), .i_rst_n(rst_n), .i_invalidate(inval),
    .i_cpu_cyc(cyc1), .i_cpu_adr(adr1), .o_cpu_rdt(cpu_rdt1), .o_cpu_ack(cpu_ack1), .o_pf_hit(pf_hit1),
    .o_wb_cyc(wb_cyc1), .o_wb_adr(wb_adr1), .i_wb_rdt(wb_rdt1), .i_wb_ack(wb_ack1)
  );

  serv_ibus_prefetch #(.ADR_W(32), .PREFETCH(0)) dut2 (
    .clk(clk), .i_rst_n(rst_n), .i_invalidate(inval2),
    .i_cpu_cyc(cyc2), .i_cpu_adr(adr2), .o_cpu_rdt(cpu_rdt2), .o_cpu_ack(cpu_ack2), .o_pf_hit(pf_hit2),
    .o_wb_cyc(wb_cyc2), .o_wb_adr(wb_adr2), .i_wb_rdt(wb_rdt2), .i_wb_ack(wb_ack2)
  );

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a == 32'h100) ? 32'h00500093 : (a ^ 32'h13579BDF);
  endfunction

  // Memory models: ack on the 4th cycle o_wb_cyc is high; log every transfer start.
  logic [31:0] bus_log1 [64];
  int n_bus1 = 0, cnt1 = 0, n_bus2 = 0, cnt2 = 0, pf_hit2_cnt = 0;
  logic prev1 = 1'b0, prev2 = 1'b0;

  always @(negedge clk) begin
    if (wb_cyc1) begin
      if (!prev1) begin
        if (n_bus1 < 64) bus_log1[n_bus1] = wb_adr1;
        n_bus1++;
      end
      cnt1++;
      resp_ack1 = (cnt1 == 4);
      wb_rdt1   = mem_word(wb_adr1);
    end else begin
      cnt1 = 0;
      resp_ack1 = 1'b0;
    end
    prev1 = wb_cyc1;
  end

  always @(negedge clk) begin
    if (wb_cyc2) begin
      if (!prev2) n_bus2++;
      cnt2++;
      wb_ack2 = (cnt2 == 4);
      wb_rdt2 = mem_word(wb_adr2);
    end else begin
      cnt2 = 0;
      wb_ack2 = 1'b0;
    end
    prev2 = wb_cyc2;
    if (pf_hit2) pf_hit2_cnt++;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Request adr on instance sel (0 = prefetching, 1 = pass-through); lat = cycles until o_cpu_ack, -1 on timeout.
  task automatic do_fetch(input int sel, input logic [31:0] adr, input logic inv_now,
                          output logic [31:0] rdt, output logic hit, output int lat);
    logic ack;
    lat = -1;
    rdt = '0;
    hit = 1'b0;
    if (sel == 0) begin cyc1 = 1'b1; adr1 = adr; inval = inv_now; end
    else begin cyc2 = 1'b1; adr2 = adr; end
    for (int n = 1; n <= 60; n++) begin
      @(negedge clk);
      inval = 1'b0;
      ack = (sel == 0) ? cpu_ack1 : cpu_ack2;
      if (ack) begin
        lat = n;
        rdt = (sel == 0) ? cpu_rdt1 : cpu_rdt2;
        hit = (sel == 0) ? pf_hit1 : pf_hit2;
        break;
      end
    end
    if (sel == 0) cyc1 = 1'b0; else cyc2 = 1'b0;
  endtask

  typedef struct {
    logic [31:0] adr;
    int          idle;   // cycles after previous ack before the request
    int          inv;    // 0 none, 1 with the request, 2 one cycle before it
    logic [31:0] rdt;
    logic        hit;
    int          lat;
    logic        cyc;    // o_wb_cyc in the ack cycle
    logic [31:0] wbadr;  // o_wb_adr in the ack cycle
  } vec_t;

  vec_t        vecs [11];
  logic [31:0] exp_log [18];

  initial begin
    logic [31:0] rdt;
    logic        hit;
    int          lat, bad;

    vecs[0]  = '{32'h00000100, 2, 0, 32'h00500093, 1'b0, 5, 1'b0, 32'h00000100};
    vecs[1]  = '{32'h00000104, 6, 0, 32'h13579ADB, 1'b1, 1, 1'b1, 32'h00000108};
    vecs[2]  = '{32'h00000108, 1, 0, 32'h13579AD7, 1'b1, 3, 1'b0, 32'h00000108};
    vecs[3]  = '{32'h00000200, 1, 0, 32'h135799DF, 1'b0, 9, 1'b0, 32'h00000200};
    vecs[4]  = '{32'h0000010C, 6, 0, 32'h13579AD3, 1'b0, 5, 1'b0, 32'h0000010C};
    vecs[5]  = '{32'h00000110, 6, 1, 32'h13579ACF, 1'b0, 5, 1'b0, 32'h00000110};
    vecs[6]  = '{32'h00000114, 6, 2, 32'h13579ACB, 1'b0, 5, 1'b0, 32'h00000114};
    vecs[7]  = '{32'h00000118, 4, 0, 32'h13579AC7, 1'b1, 1, 1'b0, 32'h00000118};
    vecs[8]  = '{32'h0000011C, 3, 2, 32'h13579AC3, 1'b0, 7, 1'b0, 32'h0000011C};
    vecs[9]  = '{32'hFFFFFFFC, 6, 0, 32'hECA86423, 1'b0, 5, 1'b0, 32'hFFFFFFFC};
    vecs[10] = '{32'h00000000, 1, 0, 32'h13579BDF, 1'b1, 4, 1'b0, 32'h00000000};
    exp_log = '{32'h100, 32'h104, 32'h108, 32'h10C, 32'h200, 32'h204, 32'h10C, 32'h110, 32'h110,
                32'h114, 32'h114, 32'h118, 32'h11C, 32'h11C, 32'h120, 32'hFFFFFFFC, 32'h0, 32'h4};

    rst_n = 1'b0; inval = 1'b0; inval2 = 1'b0; stray_ack = 1'b0;
    cyc1 = 1'b0; adr1 = '0; cyc2 = 1'b0; adr2 = '0;
    repeat (3) @(negedge clk);
    chk("reset_cpu_ack", {31'd0, cpu_ack1}, 32'd0);
    chk("reset_pf_hit",  {31'd0, pf_hit1},  32'd0);
    chk("reset_wb_cyc",  {31'd0, wb_cyc1},  32'd0);
    chk("reset_wb_adr",  wb_adr1,           32'd0);
    chk("reset_cpu_rdt", cpu_rdt1,          32'd0);
    rst_n = 1'b1;

    for (int i = 0; i < 11; i++) begin
      if (vecs[i].inv == 2) begin
        repeat (vecs[i].idle - 1) @(negedge clk);
        inval = 1'b1;
        @(negedge clk);
        inval = 1'b0;
      end else begin
        repeat (vecs[i].idle) @(negedge clk);
      end
      do_fetch(0, vecs[i].adr, vecs[i].inv == 1, rdt, hit, lat);
      $display("txn %0d: adr=%h rdt=%h hit=%0d lat=%0d wb_cyc=%0d wb_adr=%h",
               i, vecs[i].adr, rdt, hit, lat, wb_cyc1, wb_adr1);
      chk($sformatf("txn%0d_rdt", i), rdt, vecs[i].rdt);
      chk($sformatf("txn%0d_hit", i), {31'd0, hit}, {31'd0, vecs[i].hit});
      chk($sformatf("txn%0d_lat", i), 32'(lat), 32'(vecs[i].lat));
      chk($sformatf("txn%0d_wb_cyc", i), {31'd0, wb_cyc1}, {31'd0, vecs[i].cyc});
      chk($sformatf("txn%0d_wb_adr", i), wb_adr1, vecs[i].wbadr);
    end

    // Bus history: trailing prefetch of 0x4 completes into the buffer.
    repeat (10) @(negedge clk);
    chk("bus_count", 32'(n_bus1), 32'd18);
    for (int i = 0; i < 18; i++) begin
      if (i < n_bus1) chk($sformatf("bus_adr%0d", i), bus_log1[i], exp_log[i]);
    end

    // Reset in the middle of a demand transfer, then a stray ack.
    cyc1 = 1'b1; adr1 = 32'h300;
    @(negedge clk);
    chk("rst_pre_wb_cyc", {31'd0, wb_cyc1}, 32'd1);
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    $display("txn reset: wb_cyc=%0d cpu_ack=%0d wb_adr=%h rdt=%h", wb_cyc1, cpu_ack1, wb_adr1, cpu_rdt1);
    chk("rst_mid_wb_cyc",  {31'd0, wb_cyc1},  32'd0);
    chk("rst_mid_cpu_ack", {31'd0, cpu_ack1}, 32'd0);
    chk("rst_mid_wb_adr",  wb_adr1,           32'd0);
    chk("rst_mid_cpu_rdt", cpu_rdt1,          32'd0);
    rst_n = 1'b1; cyc1 = 1'b0;
    @(negedge clk);
    stray_ack = 1'b1;
    @(negedge clk);
    stray_ack = 1'b0;
    bad = 0;
    repeat (6) begin
      @(negedge clk);
      if (cpu_ack1 || wb_cyc1) bad++;
    end
    chk("stray_ack_ignored", 32'(bad), 32'd0);

    // Buffered 0x4 was lost by reset: demand miss.
    do_fetch(0, 32'h4, 1'b0, rdt, hit, lat);
    $display("txn post-reset: adr=00000004 rdt=%h hit=%0d lat=%0d", rdt, hit, lat);
    chk("postrst_rdt", rdt, 32'h13579BDB);
    chk("postrst_hit", {31'd0, hit}, 32'd0);
    chk("postrst_lat", 32'(lat), 32'd5);

    // Pass-through instance: demand fetches only.
    @(negedge clk);
    do_fetch(1, 32'h100, 1'b0, rdt, hit, lat);
    $display("txn np0: adr=00000100 rdt=%h hit=%0d lat=%0d", rdt, hit, lat);
    chk("np0_rdt", rdt, 32'h00500093);
    chk("np0_hit", {31'd0, hit}, 32'd0);
    chk("np0_lat", 32'(lat), 32'd5);
    repeat (8) @(negedge clk);
    chk("np0_bus_count", 32'(n_bus2), 32'd1);
    do_fetch(1, 32'h104, 1'b0, rdt, hit, lat);
    $display("txn np1: adr=00000104 rdt=%h hit=%0d lat=%0d", rdt, hit, lat);
    chk("np1_rdt", rdt, 32'h13579ADB);
    chk("np1_hit", {31'd0, hit}, 32'd0);
    chk("np1_lat", 32'(lat), 32'd5);
    repeat (8) @(negedge clk);
    chk("np1_bus_count", 32'(n_bus2), 32'd2);
    chk("np_pf_hit_never", 32'(pf_hit2_cnt), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
